// File: rtl/rd_ctrl_async.sv
// Read-side controller of an asynchronous FIFO: binary/Gray read pointer,
// write-pointer synchroniser, and registered empty / almost-empty / level / underflow flags.
module rd_ctrl_async #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             rd_inc,
  input  logic [ASIZE:0]   rd_ae_level,
  input  logic [ASIZE:0]   wr_ptr_gray,
  output logic [ASIZE-1:0] rd_addr,
  output logic [ASIZE:0]   rd_ptr,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic [ASIZE:0]   rd_level,
  output logic             rd_underflow
);

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbnext;
  logic [ASIZE:0] rgnext;
  logic [ASIZE:0] wq [SYNC_STAGES];
  logic [ASIZE:0] wq_s;
  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] level_next;
  logic           rd_accept;

  // Plain flop chain; the Gray input changes one bit at a time so no logic may sit between stages.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) wq[i] <= '0;
    end else begin
      wq[0] <= wr_ptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) wq[i] <= wq[i-1];
    end
  end

  assign wq_s = wq[SYNC_STAGES-1];

  always_comb begin
    wbin_s = '0;
    for (int unsigned i = 0; i <= ASIZE; i++) wbin_s[i] = ^(wq_s >> i);
  end

  always_comb begin
    rd_accept  = rd_inc & ~rd_empty;
    rbnext     = rbin + {{ASIZE{1'b0}}, rd_accept};
    rgnext     = (rbnext >> 1) ^ rbnext;
    level_next = wbin_s - rbnext;
  end

  // Flags are computed from the post-read pointer so they are valid in the same cycle the pointer moves.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin            <= '0;
      rd_ptr          <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_level        <= '0;
      rd_underflow    <= 1'b0;
    end else begin
      rbin            <= rbnext;
      rd_ptr          <= rgnext;
      rd_empty        <= (rgnext == wq_s);
      rd_almost_empty <= (level_next <= rd_ae_level);
      rd_level        <= level_next;
      rd_underflow    <= rd_inc & rd_empty;
    end
  end

  assign rd_addr = rbin[ASIZE-1:0];

endmodule

// File: tb/tb_rd_ctrl_async.sv
// Directed self-checking bench for rd_ctrl_async with ASIZE=4, SYNC_STAGES=2.
module tb_rd_ctrl_async;

  localparam int ASIZE = 4;

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic             rd_inc;
  logic [ASIZE:0]   rd_ae_level;
  logic [ASIZE:0]   wr_ptr_gray;
  logic [ASIZE-1:0] rd_addr;
  logic [ASIZE:0]   rd_ptr;
  logic             rd_empty;
  logic             rd_almost_empty;
  logic [ASIZE:0]   rd_level;
  logic             rd_underflow;

  int checks = 0;
  int errors = 0;

  rd_ctrl_async #(.ASIZE(ASIZE), .SYNC_STAGES(2)) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .rd_inc          (rd_inc),
    .rd_ae_level     (rd_ae_level),
    .wr_ptr_gray     (wr_ptr_gray),
    .rd_addr         (rd_addr),
    .rd_ptr          (rd_ptr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_rst      = 1'b1;
    rd_inc      = 1'b0;
    rd_ae_level = 5'd3;
    wr_ptr_gray = '0;
    #12;
    check("rst_ptr",   rd_ptr, 0);
    check("rst_addr",  rd_addr, 0);
    check("rst_empty", rd_empty, 1);
    check("rst_ae",    rd_almost_empty, 1);
    check("rst_level", rd_level, 0);
    check("rst_uf",    rd_underflow, 0);
    tick();
    rd_rst = 1'b0;

    // Latency: wr pointer 0->1 becomes visible after the third edge.
    wr_ptr_gray = 5'd1;
    tick();
    check("lat_e1_empty", rd_empty, 1);
    check("lat_e1_level", rd_level, 0);
    tick();
    check("lat_e2_empty", rd_empty, 1);
    check("lat_e2_level", rd_level, 0);
    tick();
    check("lat_e3_empty", rd_empty, 0);
    check("lat_e3_level", rd_level, 1);

    // Full drain: write pointer binary 16 (Gray 24).
    wr_ptr_gray = 5'd24;
    tick(); tick(); tick();
    check("drain_pre_level", rd_level, 16);
    check("drain_pre_empty", rd_empty, 0);
    check("drain_pre_ae",    rd_almost_empty, 0);
    rd_inc = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_addr", rd_addr, k);
      tick();
      check("drain_level", rd_level, 15 - k);
      check("drain_ae",    rd_almost_empty, (15 - k) <= 3);
      check("drain_empty", rd_empty, k == 15);
      check("drain_uf",    rd_underflow, 0);
    end
    check("drain_ptr",  rd_ptr, 24);
    check("drain_addr_end", rd_addr, 0);

    // Underflow: rd_inc still high while empty.
    tick();
    check("uf1",     rd_underflow, 1);
    check("uf1_ptr", rd_ptr, 24);
    tick();
    check("uf2",     rd_underflow, 1);
    check("uf2_ptr", rd_ptr, 24);
    check("uf2_addr", rd_addr, 0);
    rd_inc = 1'b0;
    tick();
    check("uf_clear", rd_underflow, 0);

    // Move the read pointer to binary 30 (Gray 17).
    wr_ptr_gray = 5'd17;
    tick(); tick(); tick();
    check("pre30_level", rd_level, 14);
    rd_inc = 1'b1;
    repeat (14) tick();
    rd_inc = 1'b0;
    check("at30_ptr",   rd_ptr, 17);
    check("at30_empty", rd_empty, 1);

    // Wrap: write pointer binary 2 (Gray 3).
    wr_ptr_gray = 5'd3;
    tick(); tick(); tick();
    check("wrap_level", rd_level, 4);
    check("wrap_empty", rd_empty, 0);
    rd_inc = 1'b1;
    repeat (4) tick();
    rd_inc = 1'b0;
    check("wrap_ptr",   rd_ptr, 3);
    check("wrap_addr",  rd_addr, 2);
    check("wrap_empty_end", rd_empty, 1);
    check("wrap_level_end", rd_level, 0);

    // Simultaneous read and write-pointer advance at level 1.
    wr_ptr_gray = 5'd2;
    tick(); tick(); tick();
    check("sim_pre_level", rd_level, 1);
    rd_inc      = 1'b1;
    wr_ptr_gray = 5'd6;
    tick();
    rd_inc = 1'b0;
    check("sim_e1_empty", rd_empty, 1);
    check("sim_e1_ptr",   rd_ptr, 2);
    check("sim_e1_uf",    rd_underflow, 0);
    tick();
    check("sim_e2_empty", rd_empty, 1);
    check("sim_e2_uf",    rd_underflow, 0);
    tick();
    check("sim_e3_empty", rd_empty, 0);
    check("sim_e3_level", rd_level, 1);
    check("sim_e3_uf",    rd_underflow, 0);

    // Almost-empty threshold extremes at level 1.
    rd_ae_level = 5'd0;
    tick();
    check("ae0", rd_almost_empty, 0);
    rd_ae_level = 5'd1;
    tick();
    check("ae1", rd_almost_empty, 1);
    rd_ae_level = 5'd16;
    tick();
    check("ae16", rd_almost_empty, 1);
    rd_ae_level = 5'd3;

    // Mid-stream reset takes effect without a clock edge and overrides rd_inc.
    rd_inc = 1'b1;
    #2;
    rd_rst = 1'b1;
    #1;
    check("mrst_ptr",   rd_ptr, 0);
    check("mrst_addr",  rd_addr, 0);
    check("mrst_empty", rd_empty, 1);
    check("mrst_ae",    rd_almost_empty, 1);
    check("mrst_level", rd_level, 0);
    tick(); tick();
    check("mrst_hold_ptr", rd_ptr, 0);
    rd_rst = 1'b0;
    rd_inc = 1'b0;
    tick();
    check("rel_e1_empty", rd_empty, 1);
    tick();
    check("rel_e2_empty", rd_empty, 1);
    tick();
    check("rel_e3_empty", rd_empty, 0);
    check("rel_e3_level", rd_level, 4);
    rd_inc = 1'b1;
    tick();
    rd_inc = 1'b0;
    check("rel_read_ptr",   rd_ptr, 1);
    check("rel_read_addr",  rd_addr, 1);
    check("rel_read_level", rd_level, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
